gpia_port_in: RTL and testbench
===============================

GPIA_PORT_IN -- requirements
Module: GPIA_PORT_IN

Interface
REQ-001 Parameter WIDTH, default 16, sets the number of port bits (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, sets the input synchroniser depth (2..4).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port out_i, input, WIDTH bits: output-latch value, returned for bits configured as outputs.
REQ-006 The block SHALL have port inp_i, input, WIDTH bits: asynchronous pin levels.
REQ-007 The block SHALL have port ddr_i, input, WIDTH bits: direction per bit, where 1 = output and 0 = input.
REQ-008 The block SHALL have port stb_i, input, 1 bit: read strobe that captures the port value.
REQ-009 The block SHALL have port rise_en_i, input, WIDTH bits: per-bit rising-edge event enable.
REQ-010 The block SHALL have port fall_en_i, input, WIDTH bits: per-bit falling-edge event enable.
REQ-011 The block SHALL have port ack_i, input, WIDTH bits: per-bit event clear, write-one-to-clear, single cycle.
REQ-012 The block SHALL have port irq_mask_i, input, WIDTH bits: per-bit interrupt enable.
REQ-013 The block SHALL have port q_o, output, WIDTH bits: captured port value.
REQ-014 The block SHALL have port evt_o, output, WIDTH bits: sticky edge-event flags.
REQ-015 The block SHALL have port irq_o, output, 1 bit: registered interrupt request.

Function
REQ-016 Each inp_i bit SHALL pass through a SYNC_STAGES-deep flop chain, whose output is s; a pin change that meets setup before edge N appears on s after edge N+SYNC_STAGES-1.
REQ-017 A prior-value register p SHALL load s on every clock, regardless of ddr_i.
REQ-018 Port value m SHALL be formed per bit as follows: m = out_i when ddr_i = 1, else m = s.
REQ-019 q_o SHALL load m on the clock edge where stb_i = 1, and SHALL hold otherwise; its latency is one cycle from stb_i.
REQ-020 A rising event for bit k SHALL be s&~p & rise_en_i & ~ddr_i, and a falling event SHALL be ~s&p & fall_en_i & ~ddr_i.
REQ-021 evt_o[k] SHALL set on the edge after an event is detected and SHALL stay set until cleared.
REQ-022 ack_i[k] = 1 SHALL clear evt_o[k] on that edge; if set and ack occur on the same edge, set SHALL win and evt_o[k] SHALL stay 1.
REQ-023 ack_i SHALL have no effect on bits with no pending event.
REQ-024 irq_o SHALL equal the registered value of |(evt_o & irq_mask_i), i.e. one cycle after the evt_o/mask change.
REQ-025 Changing irq_mask_i SHALL NOT alter evt_o.
REQ-026 A priming counter, width ceil(log2(SYNC_STAGES+2)), SHALL count clocks after reset deasserts, saturate at SYNC_STAGES+1, and suppress event detection (REQ-020) while below saturation; pins high at reset therefore SHALL produce no spurious event.
REQ-027 Toggling ddr_i alone SHALL NOT create an event, because p tracks s continuously; only a subsequent s transition on an input bit counts.
REQ-028 Pulses shorter than one clock MAY be missed; no pulse-stretching is provided.
REQ-029 With both edge enables set, every s transition SHALL set evt_o; repeated edges before ack SHALL leave a single sticky flag, with no count kept.

Reset
REQ-030 While reset_i = 1, the synchroniser chains, p, q_o, evt_o, irq_o and the priming counter SHALL all be 0, asynchronously.
REQ-031 Reset asserted mid-operation SHALL discard pending events and restart priming.
REQ-032 The first possible evt_o set SHALL occur SYNC_STAGES+2 edges after reset deasserts.

Verification (WIDTH=8, SYNC_STAGES=2)
REQ-033 Read path: ddr_i=0x0F, out_i=0xA5, inp_i=0x3C held for 3 cycles, then stb_i pulse -> q_o=0x35 the next cycle, and q_o holds while stb_i=0.
REQ-034 Rising-edge latency: after priming, rise_en_i=0x01, irq_mask_i=0x01, inp_i[0] 0->1 before edge 1 -> evt_o=0x01 after edge 3 and irq_o=1 after edge 4.
REQ-035 Set-vs-ack race: evt_o[2]=1, and a new falling edge on bit 2 is detected on the same edge as ack_i=0x04 -> evt_o[2] remains 1; a lone ack on the next cycle -> evt_o[2]=0, and irq_o falls one cycle later.
REQ-036 Priming: inp_i=0xFF and rise_en_i=0xFF during reset, reset released -> evt_o stays 0x00 for all time.
REQ-037 Direction and masking: ddr_i=0x80 with inp_i[7] toggling -> no evt_o[7]; then ddr_i[7]=0 with no pin change -> no event; then evt_o[3] set with irq_mask_i=0 -> irq_o=0, and setting mask bit 3 -> irq_o=1 one cycle later.
REQ-038 Reset mid-run: evt_o=0x12 and irq_o=1, reset_i pulsed asynchronously between edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/gpia_port_in.sv
// General-purpose input port: synchronises pins, captures the port value on a read strobe,
// and raises sticky per-bit edge events with a registered, masked interrupt request.
module gpia_port_in #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] out_i,
    input  logic [WIDTH-1:0] inp_i,
    input  logic [WIDTH-1:0] ddr_i,
    input  logic             stb_i,
    input  logic [WIDTH-1:0] rise_en_i,
    input  logic [WIDTH-1:0] fall_en_i,
    input  logic [WIDTH-1:0] ack_i,
    input  logic [WIDTH-1:0] irq_mask_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] evt_o,
    output logic             irq_o
);

    localparam int PRIME_MAX = SYNC_STAGES + 1;
    localparam int CW        = $clog2(SYNC_STAGES + 2);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] event_hit;
    logic [CW-1:0]    prime_cnt;
    logic             primed;

    assign s      = sync_q[SYNC_STAGES-1];
    assign primed = (prime_cnt == CW'(PRIME_MAX));
    assign m      = (out_i & ddr_i) | (s & ~ddr_i);
    assign rise   = s & ~p & rise_en_i & ~ddr_i;
    assign fall   = ~s & p & fall_en_i & ~ddr_i;

    // Detection stays off until the chain and p hold real pin history, so pins
    // that are already high when reset releases never look like a rising edge.
    assign event_hit = primed ? (rise | fall) : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            // NOTE: the synchroniser is a small register array, not a RAM, so every
            // stage is reset; otherwise stale levels would leak through after reset.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            p         <= '0;
            prime_cnt <= '0;
            q_o       <= '0;
            evt_o     <= '0;
            irq_o     <= 1'b0;
        end else begin
            sync_q[0] <= inp_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            p <= s;
            if (!primed) begin
                prime_cnt <= prime_cnt + CW'(1);
            end
            if (stb_i) begin
                q_o <= m;
            end
            // A new event wins over an ack arriving on the same edge.
            evt_o <= (evt_o & ~ack_i) | event_hit;
            irq_o <= |(evt_o & irq_mask_i);
        end
    end

endmodule

// File: tb/tb_gpia_port_in.sv
// Directed bench for gpia_port_in (WIDTH=8, SYNC_STAGES=2): stimulus applies inputs away
// from the clock edge and checks hand-computed expectations against the outputs.
module tb_gpia_port_in;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [7:0] out_i;
    logic [7:0] inp_i;
    logic [7:0] ddr_i;
    logic       stb_i;
    logic [7:0] rise_en_i;
    logic [7:0] fall_en_i;
    logic [7:0] ack_i;
    logic [7:0] irq_mask_i;
    logic [7:0] q_o;
    logic [7:0] evt_o;
    logic       irq_o;

    int   total = 0;
    int   bad   = 0;

    gpia_port_in #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .out_i      (out_i),
        .inp_i      (inp_i),
        .ddr_i      (ddr_i),
        .stb_i      (stb_i),
        .rise_en_i  (rise_en_i),
        .fall_en_i  (fall_en_i),
        .ack_i      (ack_i),
        .irq_mask_i (irq_mask_i),
        .q_o        (q_o),
        .evt_o      (evt_o),
        .irq_o      (irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Returns 1 time unit after the n-th rising edge, so inputs change away from the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] q, input logic [7:0] evt,
                         input logic irq);
        bit ok;
        ok = 1'b1;
        total++;
        if (q_o !== q) begin
            ok = 1'b0;
        end
        if (evt_o !== evt) begin
            ok = 1'b0;
        end
        if (irq_o !== irq) begin
            ok = 1'b0;
        end
        if (!ok) begin
            bad++;
            $display("FAIL %s: got q=%h evt=%h irq=%b, want q=%h evt=%h irq=%b",
                     name, q_o, evt_o, irq_o, q, evt, irq);
        end
    endtask

    always @(negedge clk_i) begin
        if (reset_i === 1'b1) begin
            total++;
            if (q_o !== 8'h00 || evt_o !== 8'h00 || irq_o !== 1'b0) begin
                bad++;
                $display("FAIL reset_zero: got q=%h evt=%h irq=%b during reset",
                         q_o, evt_o, irq_o);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_i    = 1'b1;
        out_i      = 8'h00;
        inp_i      = 8'hFF;
        ddr_i      = 8'h00;
        stb_i      = 1'b0;
        rise_en_i  = 8'hFF;
        fall_en_i  = 8'h00;
        ack_i      = 8'h00;
        irq_mask_i = 8'hFF;
        step(2);
        check("reset", 8'h00, 8'h00, 1'b0);

        // Pins high through reset release must never raise an event.
        reset_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("prime_hold", 8'h00, 8'h00, 1'b0);
        end

        // Read path: m = out_i on output bits, synchronised pins on input bits.
        rise_en_i  = 8'h00;
        irq_mask_i = 8'h00;
        ddr_i      = 8'h0F;
        out_i      = 8'hA5;
        inp_i      = 8'h3C;
        step(3);
        check("read_pre", 8'h00, 8'h00, 1'b0);
        stb_i = 1'b1;
        step(1);
        stb_i = 1'b0;
        check("read_cap", 8'h35, 8'h00, 1'b0);
        out_i = 8'h00;
        step(2);
        check("read_hold", 8'h35, 8'h00, 1'b0);

        // Rising-edge latency: event after edge 3, interrupt after edge 4.
        ddr_i = 8'h00;
        inp_i = 8'h00;
        step(4);
        check("rise_idle", 8'h35, 8'h00, 1'b0);
        rise_en_i  = 8'h01;
        irq_mask_i = 8'h01;
        inp_i      = 8'h01;
        step(1);
        check("rise_e1", 8'h35, 8'h00, 1'b0);
        step(1);
        check("rise_e2", 8'h35, 8'h00, 1'b0);
        step(1);
        check("rise_e3", 8'h35, 8'h01, 1'b0);
        step(1);
        check("rise_e4", 8'h35, 8'h01, 1'b1);

        // Clear bit 0, then race a new falling event on bit 2 against its ack.
        ack_i = 8'h01;
        step(1);
        ack_i = 8'h00;
        check("clr0", 8'h35, 8'h00, 1'b1);
        step(1);
        check("clr0_irq", 8'h35, 8'h00, 1'b0);
        rise_en_i  = 8'h04;
        fall_en_i  = 8'h04;
        irq_mask_i = 8'h04;
        inp_i      = 8'h05;
        step(2);
        check("b2_e2", 8'h35, 8'h00, 1'b0);
        step(1);
        check("b2_set", 8'h35, 8'h04, 1'b0);
        step(1);
        check("b2_irq", 8'h35, 8'h04, 1'b1);
        inp_i = 8'h01;
        step(2);
        check("b2_fall_pend", 8'h35, 8'h04, 1'b1);
        ack_i = 8'h04;
        step(1);
        check("race_set_wins", 8'h35, 8'h04, 1'b1);
        step(1);
        ack_i = 8'h00;
        check("lone_ack", 8'h35, 8'h00, 1'b1);
        step(1);
        check("irq_fall", 8'h35, 8'h00, 1'b0);

        // Output-direction bits never raise events, nor does flipping direction alone.
        ddr_i      = 8'h80;
        rise_en_i  = 8'hFF;
        fall_en_i  = 8'hFF;
        irq_mask_i = 8'h00;
        inp_i      = 8'h81;
        step(2);
        check("ddr_out_rise", 8'h35, 8'h00, 1'b0);
        inp_i = 8'h01;
        step(2);
        inp_i = 8'h81;
        step(3);
        check("ddr_out_toggle", 8'h35, 8'h00, 1'b0);
        ddr_i = 8'h00;
        step(4);
        check("ddr_flip_noevt", 8'h35, 8'h00, 1'b0);
        inp_i = 8'h89;
        step(3);
        check("b3_set", 8'h35, 8'h08, 1'b0);
        step(2);
        check("b3_masked", 8'h35, 8'h08, 1'b0);
        irq_mask_i = 8'h08;
        step(1);
        check("mask_irq", 8'h35, 8'h08, 1'b1);

        // Build evt=0x12 with irq high, then reset asynchronously between edges.
        ack_i      = 8'h08;
        irq_mask_i = 8'h12;
        step(1);
        ack_i = 8'h00;
        check("clr3", 8'h35, 8'h00, 1'b0);
        inp_i = 8'h9B;
        step(3);
        check("b14_set", 8'h35, 8'h12, 1'b0);
        step(1);
        check("b14_irq", 8'h35, 8'h12, 1'b1);
        #2;
        reset_i = 1'b1;
        #1;
        check("async_rst", 8'h00, 8'h00, 1'b0);
        step(1);
        reset_i = 1'b0;
        check("rst_held", 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1);
            check("reprime", 8'h00, 8'h00, 1'b0);
        end

        // All-input read after reset returns the synchronised pins.
        stb_i = 1'b1;
        step(1);
        stb_i = 1'b0;
        check("read_in", 8'h9B, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
